// File: rtl/mult_div_pkg.sv
// Shared definitions for the ALU multiply/divide unit: datapath width,
// divider state encoding, hi/lo result pair and sign helpers.
package mult_div_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // HI/LO register pair as written back by the mult/div unit.
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                  input logic              neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  // Magnitude as unsigned DATA_W; the most negative value maps to itself.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return cond_neg(v, v[DATA_W-1]);
  endfunction

endpackage

// File: rtl/divisor_seq_if.sv
// Handshake and result bus between the control unit (master) and the
// sequential divider (slave).
interface divisor_seq_if #(
  parameter int DATA_W = mult_div_pkg::DATA_W
) ();

  logic              divOp;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] div_hi;
  logic [DATA_W-1:0] div_lo;
  logic              div_busy;
  logic              div_done;
  logic              div_zero;

  modport master (
    output divOp, dividend, divisor,
    input  div_hi, div_lo, div_busy, div_done, div_zero
  );

  modport slave (
    input  divOp, dividend, divisor,
    output div_hi, div_lo, div_busy, div_done, div_zero
  );

endinterface

// File: rtl/divisor_seq.sv
// Sequential signed divider (MIPS DIV): restoring algorithm on operand
// magnitudes, one quotient bit per clock, signs fixed up in a final cycle.
// Remainder on div_hi, quotient on div_lo.
module divisor_seq
  import mult_div_pkg::*;
#(
  parameter int DATA_W = mult_div_pkg::DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  divisor_seq_if.slave  bus
);

  div_state_e        state_q, state_d;
  logic [DATA_W:0]   r_q, r_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  hilo_t             res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              zero_q, zero_d;

  logic [DATA_W+1:0] r_sh;
  logic [DATA_W+1:0] d_ext;
  logic [DATA_W-1:0] q_sh;

  // State and datapath registers; reset clears everything and aborts any op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      q_q       <= q_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
    end
  end

  // Next-state, restoring step and sign fix-up.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    q_d       = q_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    zero_d    = zero_q;

    // {R,Q} shifted left by one; R is widened so the compare cannot overflow.
    r_sh  = {r_q, q_q[DATA_W-1]};
    d_ext = {2'b00, d_q};
    q_sh  = {q_q[DATA_W-2:0], 1'b0};

    case (state_q)
      IDLE: begin
        if (bus.divOp) begin
          neg_quo_d = bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1];
          neg_rem_d = bus.dividend[DATA_W-1];
          r_d       = '0;
          q_d       = abs_val(bus.dividend);
          d_d       = abs_val(bus.divisor);
          cnt_d     = '0;
          busy_d    = 1'b1;
          if (bus.divisor == '0) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (r_sh >= d_ext) begin
          r_d = (DATA_W+1)'(r_sh - d_ext);
          q_d = q_sh | DATA_W'(1);
        end else begin
          r_d = (DATA_W+1)'(r_sh);
          q_d = q_sh;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        res_d.lo = cond_neg(q_q, neg_quo_q);
        res_d.hi = cond_neg(r_q[DATA_W-1:0], neg_rem_q);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      DONE: begin
        // Divide-by-zero: signal completion, leave hi/lo untouched.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.div_hi   = res_q.hi;
  assign bus.div_lo   = res_q.lo;
  assign bus.div_busy = busy_q;
  assign bus.div_done = done_q;
  assign bus.div_zero = zero_q;

endmodule

// File: tb/tb_divisor_seq.sv
// Self-checking bench for divisor_seq: transaction-level reference model
// (plain signed arithmetic plus a busy countdown) compared every cycle,
// directed cases with literal expectations, then randomized operations.
module tb_divisor_seq;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  divisor_seq_if #(.DATA_W(32)) bus ();

  divisor_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: {remainder, quotient} from signed arithmetic (truncating).
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return '0;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Model state: an accepted op keeps the unit busy for 33 cycles
  // (1 for divide-by-zero), then done pulses for one cycle.
  int          m_left = 0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] p_res = '0;
  logic        p_zero = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_zero <= 1'b0;
      m_hi <= '0; m_lo <= '0;
    end else if (m_left == 0) begin
      m_done <= 1'b0;
      if (bus.divOp === 1'b1) begin
        p_res  <= ref_div(bus.dividend, bus.divisor);
        p_zero <= (bus.divisor == 32'd0);
        m_zero <= (bus.divisor == 32'd0);
        m_busy <= 1'b1;
        m_left <= (bus.divisor == 32'd0) ? 1 : 33;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        if (!p_zero) begin
          m_hi <= p_res[63:32];
          m_lo <= p_res[31:0];
        end
      end else begin
        m_done <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_outputs();
    chk("div_hi",   bus.div_hi,            m_hi);
    chk("div_lo",   bus.div_lo,            m_lo);
    chk("div_busy", 32'(bus.div_busy),     32'(m_busy));
    chk("div_done", 32'(bus.div_done),     32'(m_done));
    chk("div_zero", 32'(bus.div_zero),     32'(m_zero));
  endtask

  // Every wait goes through here so outputs are compared on every cycle.
  task automatic tick();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no div_done expected div_done within 100 cycles", name);
  endtask

  // Start one op, optionally pulse divOp again mid-flight; returns edges from
  // start to done (lat) and number of cycles busy was high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, input logic [31:0] pa, input logic [31:0] pb,
                        output int lat, output int busy_cnt);
    int k;
    bus.divOp    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    lat      = -1;
    busy_cnt = 0;
    k        = 0;
    while (k < 100) begin
      tick();
      k++;
      if (bus.div_busy) busy_cnt++;
      if (bus.div_done) begin
        lat = k - 1;
        break;
      end
      if (k == 1) begin
        bus.divOp    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
      end
      if (pulse_at != 0 && k == pulse_at) begin
        bus.divOp    = 1'b1;
        bus.dividend = pa;
        bus.divisor  = pb;
      end
      if (pulse_at != 0 && k == pulse_at + 1) bus.divOp = 1'b0;
    end
    bus.divOp = 1'b0;
    if (lat < 0) timeout("done_wait");
  endtask

  initial begin
    int lat, bc, first_done, dcnt;
    logic [31:0] a, b, specials [6];
    specials[0] = 32'h8000_0000; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'h0000_0000;
    specials[3] = 32'h0000_0001; specials[4] = 32'h7FFF_FFFF; specials[5] = 32'hFFFF_FF9C;

    bus.divOp = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_hi",   bus.div_hi,        32'd0);
    chk("reset_lo",   bus.div_lo,        32'd0);
    chk("reset_busy", 32'(bus.div_busy), 32'd0);
    chk("reset_done", 32'(bus.div_done), 32'd0);
    chk("reset_zero", 32'(bus.div_zero), 32'd0);
    tick();
    #2 reset_n = 1'b1;
    tick();

    run_op(32'd100, 32'd7, 0, '0, '0, lat, bc);
    chk("lat_100_7", 32'(lat), 32'd33);
    chk("busy_100_7", 32'(bc), 32'd33);
    chk("lo_100_7", bus.div_lo, 32'd14);
    chk("hi_100_7", bus.div_hi, 32'd2);
    chk("model_lo_100_7", m_lo, 32'd14);
    chk("model_hi_100_7", m_hi, 32'd2);

    run_op(32'hFFFF_FF9C, 32'd7, 0, '0, '0, lat, bc);
    chk("lo_m100_7", bus.div_lo, 32'hFFFF_FFF2);
    chk("hi_m100_7", bus.div_hi, 32'hFFFF_FFFE);
    chk("model_hi_m100_7", m_hi, 32'hFFFF_FFFE);

    run_op(32'd100, 32'hFFFF_FFF9, 0, '0, '0, lat, bc);
    chk("lo_100_m7", bus.div_lo, 32'hFFFF_FFF2);
    chk("hi_100_m7", bus.div_hi, 32'd2);

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, '0, '0, lat, bc);
    chk("lo_ovf", bus.div_lo, 32'h8000_0000);
    chk("hi_ovf", bus.div_hi, 32'd0);
    chk("zero_ovf", 32'(bus.div_zero), 32'd0);
    chk("model_lo_ovf", m_lo, 32'h8000_0000);

    run_op(32'h7FFF_FFFF, 32'd1, 0, '0, '0, lat, bc);
    chk("lo_max_1", bus.div_lo, 32'h7FFF_FFFF);
    chk("hi_max_1", bus.div_hi, 32'd0);

    run_op(32'd100, 32'd7, 0, '0, '0, lat, bc);
    run_op(32'd5, 32'd0, 0, '0, '0, lat, bc);
    chk("lat_div0", 32'(lat), 32'd1);
    chk("busy_div0", 32'(bc), 32'd1);
    chk("zero_div0", 32'(bus.div_zero), 32'd1);
    chk("hi_div0", bus.div_hi, 32'd2);
    chk("lo_div0", bus.div_lo, 32'd14);

    run_op(32'd100, 32'd7, 5, 32'd9, 32'd3, lat, bc);
    chk("lat_ignored", 32'(lat), 32'd33);
    chk("lo_ignored", bus.div_lo, 32'd14);
    chk("hi_ignored", bus.div_hi, 32'd2);

    // Reset in the middle of an op: outputs clear at once, no done follows.
    bus.divOp = 1'b1; bus.dividend = 32'd81; bus.divisor = 32'd4;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) bus.divOp = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_hi",   bus.div_hi,        32'd0);
    chk("rst_mid_lo",   bus.div_lo,        32'd0);
    chk("rst_mid_busy", 32'(bus.div_busy), 32'd0);
    chk("rst_mid_zero", 32'(bus.div_zero), 32'd0);
    tick();
    #2 reset_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.div_done) dcnt++;
    end
    chk("rst_no_done", 32'(dcnt), 32'd0);

    // divOp held high: back-to-back ops, the second starting right after done.
    bus.divOp = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
    first_done = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (first_done != 0 && k == first_done + 1)
        chk("held_restart_busy", 32'(bus.div_busy), 32'd1);
      if (bus.div_done && first_done == 0) begin
        first_done = k;
        chk("held_lat", 32'(k - 1), 32'd33);
        chk("held_lo", bus.div_lo, 32'd3);
        chk("held_hi", bus.div_hi, 32'd0);
      end
    end
    bus.divOp = 1'b0;
    if (first_done == 0) timeout("held_first_done");
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.div_done) begin lat = k; break; end
    end
    if (lat < 0) timeout("held_second_done");
    else chk("held_second_lo", bus.div_lo, 32'd3);

    // Randomized operations with occasional ignored mid-flight requests.
    for (int n = 0; n < 150; n++) begin
      int pat;
      a = ($urandom_range(3) == 0) ? specials[$urandom_range(5)] : $urandom;
      case ($urandom_range(7))
        0:       b = 32'd0;
        1:       b = specials[$urandom_range(5)];
        2, 3:    b = ($urandom_range(1) == 1) ? 32'($urandom_range(15) + 1)
                                               : -32'($urandom_range(15) + 1);
        default: b = $urandom;
      endcase
      pat = (b != 32'd0 && $urandom_range(3) == 0) ? int'($urandom_range(30, 2)) : 0;
      run_op(a, b, pat, $urandom, $urandom, lat, bc);
      chk("rand_lat", 32'(lat), (b == 32'd0) ? 32'd1 : 32'd33);
      repeat ($urandom_range(3)) tick();
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/divisor_seq.md
Name: divisor_seq

Overview:
Sequential signed 32-bit divider; counterpart of the Booth multiplier in the ALU/mult-div unit. It executes MIPS-style DIV with results on the hi/lo buses: remainder on hi, quotient on lo. It is a multicycle restoring divider that produces one quotient bit per clock. The control unit drives it with a start pulse and waits for the done pulse before it writes HI/LO.

Parameters:
DATA_W, 32, operand and result width in bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  input  1  system clock; rising edge.
reset_n  input  1  asynchronous, active-low reset.
divOp  input  1  start request; sampled only in IDLE.
dividend  input  DATA_W  signed dividend (two's complement).
divisor  input  DATA_W  signed divisor (two's complement).
div_hi  output  DATA_W  remainder, registered.
div_lo  output  DATA_W  quotient, registered.
div_busy  output  1  high while an operation is in progress.
div_done  output  1  one-cycle pulse when a result is valid.
div_zero  output  1  divide-by-zero flag for the last accepted op.

Behaviour:
- Reset (reset_n=0, takes effect immediately): state=IDLE; div_hi=0, div_lo=0, div_busy=0, div_done=0, div_zero=0; counter and working registers cleared.
- Reset mid-operation aborts the op. No done pulse is produced and no partial result reaches the outputs.
- States: IDLE, RUN, FIX, DONE.
- IDLE, edge E0 with divOp=1:
  - Latch the operand signs.
  - R (DATA_W+1 bits) = 0; Q = |dividend|; D = |divisor|; counter = 0. Magnitudes are taken as unsigned DATA_W.
  - If divisor == 0: div_zero=1 and go to DONE.
  - Otherwise: div_zero=0, div_busy=1, go to RUN.
- RUN, edges E1..E32: {R,Q} shifted left 1. If R >= D then R = R - D and Q[0] = 1. Counter increments. After DATA_W iterations go to FIX.
- FIX, edge E33:
  - div_lo = Q, negated if the operand signs differ.
  - div_hi = R[DATA_W-1:0], negated if the dividend is negative.
  - div_done=1, div_busy=0, go to IDLE.
- Result latency: done is high during the cycle after E33, i.e. 33 cycles after the start edge, for exactly one cycle.
- Divide-by-zero path: DONE at E1 drives div_done=1 for one cycle, then IDLE. div_hi/div_lo keep their previous values. div_busy is high only for the cycle between E0 and E1.
- Rounding: quotient truncates toward zero; remainder takes the sign of the dividend.
- Overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (natural wrap) and remainder 0. No flag is raised.
- divOp while not in IDLE is ignored; there is no queueing.
- divOp held high across IDLE starts a new op on the cycle after done. The control unit must deassert it.
- Inputs are used only at E0; later changes to dividend/divisor do not affect the op in flight.
- div_hi/div_lo hold their value until the next successful FIX.
- div_zero holds until the next accepted start.

Decomposition:
- Shared package mult_div_pkg:
  - DATA_W constant.
  - State enum: IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3.
  - hi/lo result type, shared with the multiplier.
- No sub-module is needed. The abs/negate helper is a function in the package, also reusable by the multiplier.

Test Plan:
- 100 / 7 → div_lo=14, div_hi=2; div_done high exactly 33 cycles after the start edge; div_busy high for 33 cycles.
- -100 / 7 → div_lo=0xFFFFFFF2 (-14), div_hi=0xFFFFFFFE (-2). Also 100 / -7 → div_lo=-14, div_hi=2.
- 0x80000000 / 0xFFFFFFFF → div_lo=0x80000000, div_hi=0, div_zero=0. Also 0x7FFFFFFF / 1 → div_lo=0x7FFFFFFF, div_hi=0.
- Load a prior result 100/7, then 5 / 0 → div_zero=1, div_done one cycle after start, div_hi/div_lo still 2/14.
- Start 100/7, pulse divOp again at cycle 5 with 9/3 → second request ignored, result 14/2. Then reset_n low at cycle 10 of a new op → all outputs 0 immediately and no div_done.
- divOp held high for 40 cycles with 9/3 → first done gives lo=3, hi=0, and a second op starts the cycle after done.
